peripheral_dbg_soc_dii_packet_arbiter: RTL
==========================================

Name: peripheral_dbg_soc_dii_packet_arbiter

Overview:
- Packet-atomic round-robin arbiter that merges NUM_PORTS DII flit streams into one DII stream, e.g. several debug modules feeding the host-interface egress buffer toward GLIP.
- Once granted, a port owns the output until its flit with last=1 is accepted, so packets are never interleaved.
- Sits between the debug-module ring taps and the host interface module's dii_in/dii_in_ready.

Parameters:
- NUM_PORTS, 4, number of requesting DII inputs (2..16).
- SEL_W, $clog2(NUM_PORTS), width of the grant index (derived, not overridden).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  16*NUM_PORTS  flit data; port i occupies bits [16*i+15:16*i].
- in_valid  input  NUM_PORTS  per-port flit valid.
- in_last  input  NUM_PORTS  per-port end-of-packet marker.
- in_ready  output  NUM_PORTS  per-port flit accept.
- out_data  output  16  merged flit data.
- out_valid  output  1  merged flit valid.
- out_last  output  1  merged end-of-packet marker.
- out_ready  input  1  downstream accept.
- grant  output  NUM_PORTS  one-hot owner of the output; all zero when idle.
- busy  output  1  high while a packet is in flight.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous, active-high. All flops are reset on the clk edge where rst=1.
- Reset values: state=IDLE, last_sel=NUM_PORTS-1 (port 0 has first priority), grant=0, busy=0, in_ready=0, out_valid=0, out_last=0, out_data=0.
- State machine:
  - IDLE: output muxes are disabled; out_valid=0 and in_ready=0.
  - IDLE exit: if any in_valid bit is high, pick the first requesting port scanning last_sel+1, last_sel+2, ... modulo NUM_PORTS. Register it into sel and grant, then go to BUSY on the next edge.
  - Arbitration latency: exactly 1 cycle from first valid request to out_valid.
  - BUSY datapath: out_data=in_data[sel], out_valid=in_valid[sel], out_last=in_last[sel]. in_ready[sel]=out_ready; all other in_ready bits are 0. These paths are combinational, so there is no added flit latency.
  - BUSY hold: if in_valid[sel] deasserts mid-packet, the grant is held and out_valid=0 (bubble passes through). No other port may take the output.
  - BUSY exit: on out_valid & out_ready & out_last, set last_sel<=sel, grant<=0 and state<=IDLE.
  - Back-to-back packets: there is always one idle cycle between packets. A port that stays requesting is only re-granted after all other requesting ports have been served.
- Handshake rules:
  - A flit transfers when out_valid & out_ready.
  - in_ready never depends on in_valid.
  - Ports that are not granted see in_ready=0 and must hold their flit stable.
- Single-flit packet (first flit has last=1): BUSY lasts exactly 1 accepted cycle, then returns to IDLE.
- Simultaneous requests from all ports: requests are served in strict rotation from last_sel+1.
- Reset mid-packet: the packet is abandoned and the arbiter is in IDLE on the cycle after rst. Upstream is responsible for flushing the partial packet.
- busy is 1 exactly when state=BUSY.
- grant is always one-hot or zero.

Optional Feature:
- Macro: DII_ARB_PKT_CNT_EN.
- With the macro defined, an extra output pkt_count [15:0] is present:
  - reset to 0;
  - increments by 1 on every out_valid & out_ready & out_last;
  - wraps from 0xFFFF to 0x0000.
- With the macro undefined, the port and counter are absent and the rest of the behaviour is unchanged.

Test Plan (NUM_PORTS=4):
- Reset release, then port 2 sends 3 flits 0xA001..0xA003 (last on 3rd) with out_ready=1 -> out_valid rises 1 cycle after in_valid[2]. Output shows 0xA001..0xA003 on consecutive cycles, grant=4'b0100, then grant=0 and busy=0.
- All four ports hold 2-flit packets simultaneously -> packet order is ports 0,1,2,3. There is one idle cycle between packets and no interleaving of flits.
- Port 1 mid-packet drops in_valid for 3 cycles while port 3 requests -> out_valid=0 for those 3 cycles, grant stays 4'b0010 and in_ready[3]=0. Port 3 is granted only after port 1's last flit.
- Backpressure: out_ready toggles 1,0,1,0 during a 4-flit packet from port 0 -> each flit is presented until accepted. in_ready[0] mirrors out_ready and no flit is lost or duplicated.
- rst asserted while port 2 is on flit 2 of 4 -> the next cycle shows grant=0, busy=0, out_valid=0. The next request from port 0 is granted first (last_sel reset to 3).
- DII_ARB_PKT_CNT_EN defined: preload via 65537 single-flit packets -> pkt_count reads 0x0001 after wrap.

Source files
------------

// File: rtl/peripheral_dbg_soc_dii_packet_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_PORTS DII flit streams into one.
// Optional feature macro: DII_ARB_PKT_CNT_EN adds a 16-bit completed-packet counter output.
module peripheral_dbg_soc_dii_packet_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [16*NUM_PORTS-1:0] in_data,
  input  logic [NUM_PORTS-1:0]    in_valid,
  input  logic [NUM_PORTS-1:0]    in_last,
  output logic [NUM_PORTS-1:0]    in_ready,
  output logic [15:0]             out_data,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [NUM_PORTS-1:0]    grant,
  output logic                    busy
`ifdef DII_ARB_PKT_CNT_EN
  ,
  output logic [15:0]             pkt_count
`endif
);

  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     last_sel_q, last_sel_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]     pick_idx;
  logic                 pick_found;
  logic                 pkt_done;
  logic [NUM_PORTS-1:0] port_sel;
  logic [15:0]          port_data [NUM_PORTS];

  // First requester strictly after the previous owner, wrapping around.
  always_comb begin
    logic [SEL_W-1:0] idx;
    idx        = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = SEL_W'((int'(last_sel_q) + k) % NUM_PORTS);
      if (!pick_found && in_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign port_sel[gi]  = (state_q == BUSY) && (sel_q == SEL_W'(gi));
      assign port_data[gi] = in_data[16*gi +: 16];
      assign in_ready[gi]  = port_sel[gi] & out_ready;
    end
  endgenerate

  // AND-OR output mux; everything is zero while idle.
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_sel[i]) begin
        out_data  = out_data | port_data[i];
        out_valid = out_valid | in_valid[i];
        out_last  = out_last | in_last[i];
      end
    end
  end

  assign pkt_done = out_valid & out_ready & out_last;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_sel_d = last_sel_q;
    grant_d    = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          sel_d   = pick_idx;
          grant_d = NUM_PORTS'(1) << pick_idx;
        end
      end
      BUSY: begin
        if (pkt_done) begin
          state_d    = IDLE;
          last_sel_d = sel_q;
          grant_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      last_sel_q <= SEL_W'(NUM_PORTS - 1);
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_sel_q <= last_sel_d;
      grant_q    <= grant_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == BUSY);

`ifdef DII_ARB_PKT_CNT_EN
  logic [15:0] pkt_count_q, pkt_count_d;

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (pkt_done) pkt_count_d = pkt_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) pkt_count_q <= '0;
    else     pkt_count_q <= pkt_count_d;
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule
